// File: rtl/scaler2_pkg.sv
// Shared constants for the scaler2 datapath: tap count and coefficient fixed-point scaling.
package scaler2_pkg;

  localparam int TAPS = 4;
  localparam int COE_WIDTH_DFLT = 10;

  function automatic int coe_one(input int coe_w);
    return 1 << (coe_w - 2);
  endfunction

  function automatic int round_half(input int coe_w);
    return 1 << (coe_w - 3);
  endfunction

  localparam int COE_ONE = coe_one(COE_WIDTH_DFLT);
  localparam int ROUND_HALF = round_half(COE_WIDTH_DFLT);

endpackage

// File: rtl/scaler2_fifo_fwft.sv
// First-word-fall-through FIFO; the head entry is presented whenever the FIFO is non-empty.
module scaler2_fifo_fwft #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Output is forced to zero while empty so a drained or reset FIFO shows a clean bus.
  assign valid = !empty;
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cubic_interp4.sv
// 4-tap cubic interpolator: non-stalling MAC pipeline with credit-based input flow control
// and an output FWFT FIFO that absorbs downstream backpressure.
module cubic_interp4
  import scaler2_pkg::*;
#(
  parameter int PIX_WIDTH  = 8,
  parameter int COE_WIDTH  = 10,
  parameter int USER_WIDTH = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX_WIDTH-1:0]  s_pix0,
  input  logic [PIX_WIDTH-1:0]  s_pix1,
  input  logic [PIX_WIDTH-1:0]  s_pix2,
  input  logic [PIX_WIDTH-1:0]  s_pix3,
  input  logic [COE_WIDTH-1:0]  s_dx,
  input  logic [USER_WIDTH-1:0] s_user,
  output logic [COE_WIDTH-1:0]  coe_dx,
  input  logic [COE_WIDTH-1:0]  coe_f0,
  input  logic [COE_WIDTH-1:0]  coe_f1,
  input  logic [COE_WIDTH-1:0]  coe_f2,
  input  logic [COE_WIDTH-1:0]  coe_f3,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PIX_WIDTH-1:0]  m_pix,
  output logic [USER_WIDTH-1:0] m_user
);

  localparam int PROD_W = PIX_WIDTH + COE_WIDTH + 1;
  localparam int ACC_W  = PROD_W + 2;
  localparam int SHIFT  = $clog2(coe_one(COE_WIDTH));
  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(round_half(COE_WIDTH));
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_WIDTH) - 1);

  function automatic logic [PIX_WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + RND) >>> SHIFT;
    if (r[ACC_W-1])    return '0;
    if (r > PIX_MAX)   return '1;
    return r[PIX_WIDTH-1:0];
  endfunction

  logic                         accept;
  logic                         pop;
  logic [CRED_W-1:0]            credit;
  logic                         vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;
  logic [PIX_WIDTH-1:0]         pix_p0 [TAPS];
  logic [PIX_WIDTH-1:0]         pix_p1 [TAPS];
  logic signed [PROD_W-1:0]     prod_p2 [TAPS];
  logic signed [ACC_W-1:0]      sum_p3;
  logic [PIX_WIDTH-1:0]         pix_p4;
  logic [USER_WIDTH-1:0]        user_p0, user_p1, user_p2, user_p3, user_p4;
  logic signed [COE_WIDTH-1:0]  coe_f [TAPS];
  logic [PIX_WIDTH+USER_WIDTH-1:0] fifo_dout;

  assign coe_f[0] = coe_f0;
  assign coe_f[1] = coe_f1;
  assign coe_f[2] = coe_f2;
  assign coe_f[3] = coe_f3;

  // Credit covers every accepted beat not yet popped, so the FIFO can never overflow.
  assign s_ready = !rst && (credit < CRED_W'(FIFO_DEPTH));
  assign accept  = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
      credit <= '0;
      coe_dx <= '0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
      if (accept) coe_dx <= s_dx;
      if (accept && !pop)      credit <= credit + 1'b1;
      else if (!accept && pop) credit <= credit - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // S0: capture taps; coe_dx goes to the table in parallel
    pix_p0[0] <= s_pix0;
    pix_p0[1] <= s_pix1;
    pix_p0[2] <= s_pix2;
    pix_p0[3] <= s_pix3;
    user_p0   <= s_user;
    // S1: align taps with the table's registered coefficient output
    pix_p1  <= pix_p0;
    user_p1 <= user_p0;
    // S2: products
    for (int i = 0; i < TAPS; i++) begin
      prod_p2[i] <= PROD_W'($signed({1'b0, pix_p1[i]})) * PROD_W'(coe_f[i]);
    end
    user_p2 <= user_p1;
    // S3: sum with guard bits
    sum_p3  <= ACC_W'(prod_p2[0]) + ACC_W'(prod_p2[1]) + ACC_W'(prod_p2[2]) + ACC_W'(prod_p2[3]);
    user_p3 <= user_p2;
    // S4: round and clamp to pixel range
    pix_p4  <= round_sat(sum_p3);
    user_p4 <= user_p3;
  end

  scaler2_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_WIDTH + USER_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p4),
    .din   ({pix_p4, user_p4}),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (m_valid)
  );

  assign {m_pix, m_user} = fifo_dout;

endmodule

// File: tb/tb_cubic_interp4.sv
// Bench for cubic_interp4: Keys (a=-0.5) registered coefficient ROM, queue-based reference model.
module tb_cubic_interp4;
  import scaler2_pkg::*;

  localparam int PW = 8;
  localparam int CW = 10;
  localparam int UW = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready;
  logic [PW-1:0] s_pix0, s_pix1, s_pix2, s_pix3;
  logic [CW-1:0] s_dx;
  logic [UW-1:0] s_user;
  logic [CW-1:0] coe_dx;
  logic [CW-1:0] coe_f0, coe_f1, coe_f2, coe_f3;
  logic          m_valid, m_ready;
  logic [PW-1:0] m_pix;
  logic [UW-1:0] m_user;

  int n_checks, n_errors, n_acc, n_pop;
  logic last_acc;
  logic [PW+UW-1:0] exp_q [$];

  always #5 clk = ~clk;

  cubic_interp4 #(
    .PIX_WIDTH (PW), .COE_WIDTH (CW), .USER_WIDTH (UW), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst (rst),
    .s_valid (s_valid), .s_ready (s_ready),
    .s_pix0 (s_pix0), .s_pix1 (s_pix1), .s_pix2 (s_pix2), .s_pix3 (s_pix3),
    .s_dx (s_dx), .s_user (s_user),
    .coe_dx (coe_dx),
    .coe_f0 (coe_f0), .coe_f1 (coe_f1), .coe_f2 (coe_f2), .coe_f3 (coe_f3),
    .m_valid (m_valid), .m_ready (m_ready), .m_pix (m_pix), .m_user (m_user)
  );

  function automatic logic [CW-1:0] keys_coef(input logic [CW-1:0] dx, input int k);
    real a, t, w;
    a = -0.5;
    t = real'(dx) / real'(1 << CW);
    case (k)
      0:       w = a * (t*t*t - 2.0*t*t + t);
      1:       w = (a + 2.0)*t*t*t - (a + 3.0)*t*t + 1.0;
      2:       w = -(a + 2.0)*t*t*t + (2.0*a + 3.0)*t*t - a*t;
      default: w = -a*t*t*t + a*t*t;
    endcase
    return CW'(int'(w * real'(COE_ONE)));
  endfunction

  // Table model: one-cycle registered ROM addressed by coe_dx.
  always @(posedge clk) begin
    coe_f0 <= keys_coef(coe_dx, 0);
    coe_f1 <= keys_coef(coe_dx, 1);
    coe_f2 <= keys_coef(coe_dx, 2);
    coe_f3 <= keys_coef(coe_dx, 3);
  end

  function automatic int ref_pix(input logic [CW-1:0] dx, input logic [31:0] pix4);
    int sum, v, q;
    logic [CW-1:0] f;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      f = keys_coef(dx, k);
      sum += int'(pix4[8*k +: 8]) * int'($signed(f));
    end
    v = sum + ROUND_HALF;
    q = (v >= 0) ? v / COE_ONE : -((-v + COE_ONE - 1) / COE_ONE);
    if (q < 0)   q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic r, input logic [CW-1:0] dx,
                      input logic [31:0] pix4, input logic [UW-1:0] u);
    logic [PW+UW-1:0] e;
    @(negedge clk);
    s_valid = v; m_ready = r; s_dx = dx; s_user = u;
    s_pix0 = pix4[7:0]; s_pix1 = pix4[15:8]; s_pix2 = pix4[23:16]; s_pix3 = pix4[31:24];
    #1;
    if (!rst) check_val("credit_ready", 32'(s_ready), 32'(exp_q.size() < DEPTH));
    last_acc = s_valid && s_ready;
    if (m_valid && m_ready) begin
      n_pop++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check_val("out_pix", 32'(m_pix), 32'(e[PW+UW-1:UW]));
      check_val("out_user", 32'(m_user), 32'(e[UW-1:0]));
    end
    if (last_acc) begin
      n_acc++;
      exp_q.push_back({PW'(ref_pix(dx, pix4)), u});
    end
  endtask

  task automatic rstep(input logic v, input logic r);
    step(v, r, CW'($urandom), $urandom, UW'($urandom));
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    #1;
    check_val("rst_s_ready", 32'(s_ready), 32'(0));
    check_val("rst_m_valid", 32'(m_valid), 32'(0));
    check_val("rst_m_pix", 32'(m_pix), 32'(0));
    check_val("rst_m_user", 32'(m_user), 32'(0));
    check_val("rst_coe_dx", 32'(coe_dx), 32'(0));
    exp_q.delete();
    rst = 1'b0;
    #1;
    check_val("post_rst_s_ready", 32'(s_ready), 32'(1));
  endtask

  task automatic drain();
    for (int j = 0; j < 200 && exp_q.size() > 0; j++) rstep(1'b0, 1'b1);
    rstep(1'b0, 1'b1);
    check_val("drain_left", 32'(exp_q.size()), 32'(0));
    check_val("drain_m_valid", 32'(m_valid), 32'(0));
  endtask

  task automatic run_one(input logic [CW-1:0] dx, input logic [31:0] pix4, input logic [UW-1:0] u,
                         input int exp_pix, input bit chk_lat);
    int lat;
    step(1'b1, 1'b0, dx, pix4, u);
    check_val("dir_accept", 32'(last_acc), 32'(1));
    lat = -1;
    for (int j = 1; j <= 20; j++) begin
      step(1'b0, 1'b0, '0, '0, '0);
      if (m_valid) begin
        lat = j - 1;
        break;
      end
    end
    if (chk_lat) check_val("latency", 32'(lat), 32'(5));
    check_val("dir_pix", 32'(m_pix), 32'(exp_pix));
    check_val("dir_user", 32'(m_user), 32'(u));
    step(1'b0, 1'b1, '0, '0, '0);
  endtask

  initial begin
    int a0, p0, cyc;
    logic v, r;
    n_checks = 0; n_errors = 0; n_acc = 0; n_pop = 0; last_acc = 1'b0;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_dx = '0; s_user = '0;
    s_pix0 = '0; s_pix1 = '0; s_pix2 = '0; s_pix3 = '0;
    apply_reset(3);

    run_one(CW'(0),   {8'd40, 8'd30, 8'd20, 8'd10}, 2'b01, 20, 1'b1);
    run_one(CW'(512), {8'd4, 8'd3, 8'd2, 8'd1},     2'b10, 3,  1'b0);
    run_one(CW'(512), {8'd0, 8'd255, 8'd255, 8'd0}, 2'b11, 255, 1'b0);
    run_one(CW'(512), {8'd255, 8'd0, 8'd0, 8'd255}, 2'b00, 0,  1'b0);

    // Full backpressure: exactly FIFO_DEPTH beats admitted, then released in order.
    a0 = n_acc;
    repeat (20) rstep(1'b1, 1'b0);
    check_val("fill_accepts", 32'(n_acc - a0), 32'(DEPTH));
    check_val("fill_s_ready", 32'(s_ready), 32'(0));
    p0 = n_pop;
    repeat (20) rstep(1'b0, 1'b1);
    check_val("fill_pops", 32'(n_pop - p0), 32'(DEPTH));
    check_val("fill_left", 32'(exp_q.size()), 32'(0));

    // Reset with 3 beats buffered and 4 in the pipeline.
    repeat (3) rstep(1'b1, 1'b0);
    repeat (6) rstep(1'b0, 1'b0);
    repeat (4) rstep(1'b1, 1'b0);
    apply_reset(1);
    repeat (12) rstep(1'b1, 1'b1);
    drain();

    // Random valid/ready traffic with periodic stall bursts.
    a0 = n_acc;
    cyc = 0;
    while ((n_acc - a0) < 10000 && cyc < 60000) begin
      v = ($urandom_range(0, 99) < 80);
      r = ((cyc % 256) < 40) ? 1'b0 : ($urandom_range(0, 99) < 60);
      rstep(v, r);
      cyc++;
    end
    check_val("rand_beats", 32'(n_acc - a0), 32'(10000));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
